vxe_pipe_rcv: RTL and testbench

Receive end of a vxe_pipe_2 instance. The pipe is valid-only and has no backpressure, so this block does two jobs:
- Credit tracking: it counts words issued into the pipe and tells the producer when it may issue.
- Buffering: it stores arriving pipe words in a FIFO and presents them to a downstream valid/ready consumer.
It sits directly after the pipe's o_data/o_vld outputs.

---
 rtl/vxe_pipe_pkg.sv | 22 ++
 rtl/vxe_pipe_rcv_fifo.sv | 55 +++++
 rtl/vxe_pipe_rcv.sv | 95 +++++++++
 tb/tb_vxe_pipe_rcv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vxe_pipe_pkg.sv
// Shared definitions for the vxe_pipe receive side: counter width helper and
// debug encodings for the protocol-error causes.
package vxe_pipe_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_NOCREDIT,
      ERR_OVERFLOW,
      ERR_SPURIOUS
   } err_cause_e;

   // Bits needed to hold values 0..depth inclusive.
   function automatic int unsigned cw_calc(input int unsigned depth);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) <= 64'(depth)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vxe_pipe_rcv_fifo.sv
// Word FIFO for the pipe receiver: storage, wrapping pointers and occupancy.
// Pushes into a full FIFO are accepted only when a pop frees a slot the same cycle.
module vxe_pipe_rcv_fifo
   import vxe_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   localparam int CW        = cw_calc(DEPTH),
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  push_en;
   logic                  pop_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vxe_pipe_rcv.sv
// Receive end of vxe_pipe_2: credit accounting toward the producer plus a FIFO
// toward a valid/ready consumer. Define VXE_PIPE_RCV_BYPASS_EN for a zero-latency empty-FIFO path.
module vxe_pipe_rcv
   import vxe_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   localparam int CW        = cw_calc(DEPTH)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  i_issue,
   output logic                  o_credit,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_vld,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_vld,
   input  logic                  i_rdy,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [CW-1:0]         o_used
);

   logic [CW-1:0]         used_q;
   logic [CW-1:0]         used_d;
   logic                  err_q;
   err_cause_e            cause;
   logic                  bypass;
   logic                  pop;
   logic                  fifo_pop_eff;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

`ifdef VXE_PIPE_RCV_BYPASS_EN
   assign bypass = fifo_empty && i_vld && i_rdy;
`else
   assign bypass = 1'b0;
`endif

   vxe_pipe_rcv_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (i_vld && !bypass),
      .wdata (i_data),
      .pop   (i_rdy),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign o_vld        = !fifo_empty || bypass;
   assign o_data       = bypass ? i_data : fifo_rdata;
   assign pop          = o_vld && i_rdy;
   assign fifo_pop_eff = i_rdy && !fifo_empty;
   assign o_credit     = (used_q < CW'(DEPTH));
   assign o_busy       = (used_q != '0);
   assign o_used       = used_q;
   assign o_err        = err_q;

   // Saturate at both ends so illegal issue/pop traffic cannot wrap the counter.
   always_comb begin
      used_d = used_q;
      if (i_issue && !pop && (used_q != CW'(DEPTH)))
         used_d = used_q + CW'(1);
      else if (pop && !i_issue && (used_q != '0))
         used_d = used_q - CW'(1);
   end

   always_comb begin
      cause = ERR_NONE;
      if (i_issue && !o_credit)
         cause = ERR_NOCREDIT;
      else if (i_vld && fifo_full && !fifo_pop_eff)
         cause = ERR_OVERFLOW;
      else if (i_vld && (fifo_count >= used_q))
         cause = ERR_SPURIOUS;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         used_q <= '0;
         err_q  <= 1'b0;
      end else begin
         used_q <= used_d;
         if (cause != ERR_NONE) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vxe_pipe_rcv.sv
// Directed bench for vxe_pipe_rcv: a vector table for the single-word and
// spurious-arrival flows, then hand sequences for burst, wrap, reset and bypass.
module tb_vxe_pipe_rcv;

   logic        clk;
   logic        nrst;
   logic        i_issue;
   logic        o_credit;
   logic [31:0] i_data;
   logic        i_vld;
   logic [31:0] o_data;
   logic        o_vld;
   logic        i_rdy;
   logic        o_busy;
   logic        o_err;
   logic [3:0]  o_used;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        issue;
      logic        vld;
      logic [31:0] data;
      logic        rdy;
      logic        credit;
      logic        ovld;
      logic [31:0] odata;
      logic        busy;
      logic        err;
      int          used;
   } vec_t;

   vec_t tbl[9];

   vxe_pipe_rcv #(
      .DATA_WIDTH (32),
      .DEPTH      (8)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .i_issue  (i_issue),
      .o_credit (o_credit),
      .i_data   (i_data),
      .i_vld    (i_vld),
      .o_data   (o_data),
      .o_vld    (o_vld),
      .i_rdy    (i_rdy),
      .o_busy   (o_busy),
      .o_err    (o_err),
      .o_used   (o_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic issue, logic vld, logic [31:0] data, logic rdy,
                               logic credit, logic ovld, logic [31:0] odata,
                               logic busy, logic err, int used);
      vec_t v;
      v.issue = issue; v.vld = vld; v.data = data; v.rdy = rdy;
      v.credit = credit; v.ovld = ovld; v.odata = odata;
      v.busy = busy; v.err = err; v.used = used;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic issue, input logic vld, input logic [31:0] data, input logic rdy);
      @(negedge clk);
      i_issue = issue;
      i_vld   = vld;
      i_data  = data;
      i_rdy   = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst    = 1'b0;
      i_issue = 1'b0;
      i_vld   = 1'b0;
      i_data  = '0;
      i_rdy   = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      // Single word through a 5-stage pipe, then a spurious arrival.
      tbl[0] = mk(1, 0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 1);
      tbl[1] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 1);
      tbl[2] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 1);
      tbl[3] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 1);
      tbl[4] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 1);
      tbl[5] = mk(0, 1, 32'hBEEF_0001, 0, 1, 1, 32'hBEEF_0001, 1, 0, 1);
      tbl[6] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 0, 0);
      tbl[7] = mk(0, 1, 32'hCAFE_0007, 0, 1, 1, 32'hCAFE_0007, 0, 1, 0);
      tbl[8] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 1, 0);

      nrst = 1'b0; i_issue = 1'b0; i_vld = 1'b0; i_data = '0; i_rdy = 1'b0;
      do_reset();
      #1;
      chk("rst.ovld",   32'(o_vld),    32'd0);
      chk("rst.credit", 32'(o_credit), 32'd1);
      chk("rst.busy",   32'(o_busy),   32'd0);
      chk("rst.used",   32'(o_used),   32'd0);
      chk("rst.data",   o_data,        32'd0);
      chk("rst.err",    32'(o_err),    32'd0);

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].issue, tbl[i].vld, tbl[i].data, tbl[i].rdy);
         tick();
         chk($sformatf("v%0d.credit", i), 32'(o_credit), 32'(tbl[i].credit));
         chk($sformatf("v%0d.ovld", i),   32'(o_vld),    32'(tbl[i].ovld));
         chk($sformatf("v%0d.odata", i),  o_data,        tbl[i].odata);
         chk($sformatf("v%0d.busy", i),   32'(o_busy),   32'(tbl[i].busy));
         chk($sformatf("v%0d.err", i),    32'(o_err),    32'(tbl[i].err));
         chk($sformatf("v%0d.used", i),   32'(o_used),   32'(tbl[i].used));
      end

      // Burst of 8 with the consumer stalled, then a credit violation, then drain.
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         drive(1, 0, 32'h0, 0);
         tick();
         chk($sformatf("burst.used%0d", i),   32'(o_used),   32'(i));
         chk($sformatf("burst.credit%0d", i), 32'(o_credit), (i < 8) ? 32'd1 : 32'd0);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 32'hBEEF_0000 + 32'(i), 0);
         tick();
         chk($sformatf("burst.ovld%0d", i), 32'(o_vld), 32'd1);
         chk($sformatf("burst.head%0d", i), o_data,     32'hBEEF_0001);
      end
      chk("burst.err", 32'(o_err), 32'd0);
      drive(1, 0, 32'h0, 0);
      tick();
      chk("nocredit.err",    32'(o_err),    32'd1);
      chk("nocredit.used",   32'(o_used),   32'd8);
      chk("nocredit.credit", 32'(o_credit), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 0, 32'h0, 1);
         tick();
         chk($sformatf("drain.used%0d", i),   32'(o_used),   32'(8 - i));
         chk($sformatf("drain.credit%0d", i), 32'(o_credit), 32'd1);
         chk($sformatf("drain.ovld%0d", i),   32'(o_vld),    (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("drain.data%0d", i),   o_data,
             (i < 8) ? 32'hBEEF_0000 + 32'(i + 1) : 32'h0);
      end
      chk("drain.busy", 32'(o_busy), 32'd0);

      // used=3, count=2, then 20 cycles of simultaneous issue/arrive/pop across wrap.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'h0, 0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 32'hA5A5_0000 + 32'(i), 0);
         tick();
      end
      chk("sim.used0", 32'(o_used), 32'd3);
      for (int k = 0; k < 20; k++) begin
         drive(1, 1, 32'hA5A5_0000 + 32'(k + 2), 1);
         #1;
         chk($sformatf("sim.head%0d", k), o_data, 32'hA5A5_0000 + 32'(k));
         tick();
         chk($sformatf("sim.used%0d", k + 1), 32'(o_used), 32'd3);
         chk($sformatf("sim.ovld%0d", k),     32'(o_vld),  32'd1);
      end
      for (int k = 20; k < 22; k++) begin
         drive(0, 0, 32'h0, 1);
         #1;
         chk($sformatf("sim.tail%0d", k), o_data, 32'hA5A5_0000 + 32'(k));
         tick();
      end
      chk("sim.used_end", 32'(o_used), 32'd1);
      chk("sim.ovld_end", 32'(o_vld),  32'd0);
      chk("sim.busy_end", 32'(o_busy), 32'd1);
      chk("sim.err",      32'(o_err),  32'd0);

      // Asynchronous reset with 5 words buffered.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'h0, 0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 32'h5000_0000 + 32'(i), 0);
         tick();
      end
      chk("mid.used", 32'(o_used), 32'd5);
      chk("mid.ovld", 32'(o_vld),  32'd1);
      @(negedge clk);
      #2;
      nrst = 1'b0;
      i_vld = 1'b0;
      #1;
      chk("arst.ovld",   32'(o_vld),    32'd0);
      chk("arst.credit", 32'(o_credit), 32'd1);
      chk("arst.used",   32'(o_used),   32'd0);
      chk("arst.busy",   32'(o_busy),   32'd0);
      chk("arst.data",   o_data,        32'd0);
      @(negedge clk);
      nrst = 1'b1;

`ifdef VXE_PIPE_RCV_BYPASS_EN
      do_reset();
      drive(1, 0, 32'h0, 0);
      tick();
      drive(0, 1, 32'h1234_5678, 1);
      #1;
      chk("byp.ovld", 32'(o_vld), 32'd1);
      chk("byp.data", o_data,     32'h1234_5678);
      tick();
      chk("byp.used", 32'(o_used), 32'd0);
      chk("byp.err",  32'(o_err),  32'd0);
      drive(0, 0, 32'h0, 0);
      tick();
      chk("byp.empty", 32'(o_vld), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
